// File: rtl/stream_fifo_pkg.sv
// Shared defaults and the pointer wrap helper for stream_fifo.
package stream_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    // Wraps by comparison with the last index so non-power-of-two depths work.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array storage: synchronous write, combinational read; no reset on contents.
module stream_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO; a word pushed at edge N is visible after N, poppable from N+1.
// s_ready depends only on registered count, so a full FIFO never passes a word through.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int          WIDTH    = FIFO_WIDTH_DEF,
    parameter int          DEPTH    = FIFO_DEPTH_DEF,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter int          CNT_W    = $clog2(DEPTH + 1),
    parameter int          AF_LEVEL = DEPTH - 2,
    parameter              AE_LEVEL = 'd2,
    parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}},
    parameter string       NAME     = "stream_fifo"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  rd_data;
    logic              push;
    logic              pop;

    assign s_ready      = (count_q != CNT_W'(DEPTH));
    assign m_valid      = (count_q != '0);
    assign push         = s_valid & s_ready;
    assign pop          = m_valid & m_ready;
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign m_data       = m_valid ? rd_data : RST_DATA;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ADDR_W'(next_ptr(32'(wr_ptr_q), 32'(DEPTH)));
            end
            if (pop) begin
                rd_ptr_d = ADDR_W'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A flushed push must not land in storage.
    stream_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(s_valid && s_ready && count_q == CNT_W'(DEPTH)))
                else $error("%s: push while full", NAME);
            assert (!(m_valid && m_ready && count_q == '0))
                else $error("%s: pop while empty", NAME);
            assert (count_q <= CNT_W'(DEPTH))
                else $error("%s: count exceeds depth", NAME);
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo at DEPTH=16 and DEPTH=5.
module tb_stream_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_flush, a_sv, a_mr;
    logic [7:0] a_sd;
    logic       a_sr, a_mv, a_af, a_ae;
    logic [7:0] a_md;
    logic [4:0] a_cnt;

    logic       b_flush, b_sv, b_mr;
    logic [7:0] b_sd;
    logic       b_sr, b_mv, b_af, b_ae;
    logic [7:0] b_md;
    logic [2:0] b_cnt;

    int total = 0;
    int bad   = 0;

    stream_fifo #(.WIDTH(8), .DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
        .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae)
    );

    stream_fifo #(.WIDTH(8), .DEPTH(5)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
        .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_sv = 0; a_mr = 0; a_sd = 8'h00;
        b_flush = 0; b_sv = 0; b_mr = 0; b_sd = 8'h00;
        #3;
        chk("rst_count", a_cnt, 0);
        chk("rst_s_ready", a_sr, 1);
        chk("rst_m_valid", a_mv, 0);
        chk("rst_m_data", a_md, 8'h00);
        chk("rst_af", a_af, 0);
        chk("rst_ae", a_ae, 1);
        #9 rst_n = 1'b1;
        #1;

        // Test 1: three pushes, then drain in order
        a_sv = 1; a_sd = 8'h11; tick();
        a_sd = 8'h22; tick();
        chk("t1_ae_at2", a_ae, 1);
        a_sd = 8'h33; tick();
        a_sv = 0;
        chk("t1_count3", a_cnt, 3);
        chk("t1_head", a_md, 8'h11);
        chk("t1_ae_at3", a_ae, 0);
        chk("t1_mv", a_mv, 1);
        a_mr = 1; tick();
        chk("t1_out2", a_md, 8'h22);
        chk("t1_cnt2", a_cnt, 2);
        tick();
        chk("t1_out3", a_md, 8'h33);
        tick();
        chk("t1_cnt0", a_cnt, 0);
        chk("t1_mv0", a_mv, 0);
        chk("t1_md_rst", a_md, 8'h00);
        a_mr = 0;

        // Test 2: fill to 16
        a_sv = 1;
        for (int i = 0; i < 16; i++) begin
            a_sd = 8'h40 + 8'(i);
            tick();
            chk("t2_cnt", a_cnt, i + 1);
            chk("t2_af", a_af, (i + 1 >= 14) ? 1 : 0);
        end
        chk("t2_full_sr", a_sr, 0);
        a_sd = 8'hFF; tick();
        chk("t2_ign_cnt", a_cnt, 16);
        chk("t2_ign_head", a_md, 8'h40);
        a_sv = 0; a_mr = 1; tick();
        a_mr = 0;
        chk("t2_pop_cnt", a_cnt, 15);
        chk("t2_pop_sr", a_sr, 1);
        chk("t2_pop_head", a_md, 8'h41);

        // Test 4: flush with simultaneous push/pop at count 7
        a_flush = 1; tick();
        a_flush = 0;
        chk("t4_pre_flush", a_cnt, 0);
        a_sv = 1;
        for (int i = 0; i < 7; i++) begin
            a_sd = 8'h70 + 8'(i);
            tick();
        end
        chk("t4_cnt7", a_cnt, 7);
        a_flush = 1; a_sd = 8'hAA; a_mr = 1; tick();
        a_flush = 0; a_sv = 0; a_mr = 0;
        chk("t4_cnt0", a_cnt, 0);
        chk("t4_mv0", a_mv, 0);
        a_sv = 1; a_sd = 8'hA1; tick();
        a_sv = 0;
        chk("t4_next_head", a_md, 8'hA1);
        chk("t4_next_cnt", a_cnt, 1);

        // Test 5: async reset mid-cycle with count 9
        a_sv = 1;
        for (int i = 0; i < 8; i++) begin
            a_sd = 8'h90 + 8'(i);
            tick();
        end
        a_sv = 0;
        chk("t5_cnt9", a_cnt, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_cnt", a_cnt, 0);
        chk("t5_async_mv", a_mv, 0);
        chk("t5_async_md", a_md, 8'h00);
        chk("t5_async_sr", a_sr, 1);
        #2 rst_n = 1'b1;
        a_sv = 1; a_sd = 8'h5C; tick();
        a_sv = 0;
        chk("t5_first_word", a_md, 8'h5C);
        chk("t5_cnt1", a_cnt, 1);
        a_mr = 1; tick();
        a_mr = 0;
        chk("t5_drained", a_cnt, 0);

        // Test 6: push into empty with m_ready high
        a_sv = 1; a_sd = 8'h3E; a_mr = 1; tick();
        a_sv = 0;
        chk("t6_mv", a_mv, 1);
        chk("t6_md", a_md, 8'h3E);
        chk("t6_cnt", a_cnt, 1);
        tick();
        a_mr = 0;
        chk("t6_cnt0", a_cnt, 0);

        // Test 3: DEPTH=5 continuous streaming, pointers wrap repeatedly
        b_sv = 1; b_mr = 1;
        for (int i = 0; i < 20; i++) begin
            b_sd = 8'h10 + 8'(i);
            tick();
            chk("t3_cnt", b_cnt, 1);
            chk("t3_order", b_md, 8'h10 + i);
        end
        b_sv = 0;
        tick();
        b_mr = 0;
        chk("t3_end_cnt", b_cnt, 0);
        chk("t3_end_mv", b_mv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
